// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads/stores over a req/gnt + rvalid port and drives the MEM/WB register.
// Optional access abort after TIMEOUT idle cycles when MEM_TIMEOUT_EN is defined.
module mem_access_stage #(
  parameter int DW      = 32,
  parameter int RW      = 4,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] alu_res,
  input  logic [DW-1:0] st_data,
  input  logic [RW-1:0] wr_dest,
  input  logic          wmem,
  input  logic          rmem,
  input  logic          wreg,
  input  logic          jmp,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          wb_valid,
  output logic [DW-1:0] wb_data,
  output logic [RW-1:0] wb_dest,
  output logic          wb_wreg,
  output logic          wb_jmp,
  output logic          mem_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT_R = 2'd2} state_t;

  state_t        state_r, next_s;
  logic [RW-1:0] op_dest_r;
  logic          op_wreg_r, op_jmp_r;
  logic          issue_s, pass_s, wr_done_s, rd_gnt_s, rd_done_s, abort_s;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] tmo_cnt_r;
  logic          waiting_s, progress_s;

  assign waiting_s  = (state_r == REQ) || (state_r == WAIT_R);
  assign progress_s = ((state_r == REQ) && mem_gnt) || ((state_r == WAIT_R) && mem_rvalid);
  assign abort_s    = waiting_s && !progress_s && (tmo_cnt_r == CW'(TIMEOUT - 1));

  // Counts consecutive waiting cycles without gnt/rvalid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_r <= '0;
    end else if (!waiting_s || progress_s || abort_s) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + CW'(1);
    end
  end
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT > 0);
  assign abort_s          = 1'b0;
`endif

  // Next state, stall and per-cycle event decode; stall drops in every completion cycle
  always_comb begin
    next_s    = state_r;
    stall     = 1'b0;
    issue_s   = 1'b0;
    pass_s    = 1'b0;
    wr_done_s = 1'b0;
    rd_gnt_s  = 1'b0;
    rd_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && (wmem || rmem)) begin
          issue_s = 1'b1;
          stall   = 1'b1;
          next_s  = REQ;
        end else begin
          pass_s = in_valid;
        end
      end
      REQ: begin
        if (mem_gnt && mem_we) begin
          wr_done_s = 1'b1;
          next_s    = IDLE;
        end else if (mem_gnt) begin
          rd_gnt_s = 1'b1;
          stall    = 1'b1;
          next_s   = WAIT_R;
        end else if (abort_s) begin
          next_s = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          rd_done_s = 1'b1;
          next_s    = IDLE;
        end else if (abort_s) begin
          next_s = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: next_s = IDLE;
    endcase
  end

  // State register, memory request port and latched instruction fields
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      op_dest_r <= '0;
      op_wreg_r <= 1'b0;
      op_jmp_r  <= 1'b0;
    end else begin
      state_r <= next_s;
      if (issue_s) begin
        mem_req   <= 1'b1;
        mem_we    <= wmem;
        mem_addr  <= alu_res;
        mem_wdata <= st_data;
        op_dest_r <= wr_dest;
        op_wreg_r <= wreg;
        op_jmp_r  <= jmp;
      end else if (wr_done_s || rd_gnt_s || abort_s) begin
        mem_req <= 1'b0;
      end
    end
  end

  // MEM/WB register: one wb_valid pulse per completed or aborted instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_dest  <= '0;
      wb_wreg  <= 1'b0;
      wb_jmp   <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      wb_valid <= pass_s || wr_done_s || rd_done_s || abort_s;
      mem_err  <= abort_s;
      if (pass_s) begin
        wb_data <= alu_res;
        wb_dest <= wr_dest;
        wb_wreg <= wreg;
        wb_jmp  <= jmp;
      end else if (wr_done_s || rd_done_s) begin
        wb_data <= rd_done_s ? mem_rdata : mem_addr;
        wb_dest <= op_dest_r;
        wb_wreg <= op_wreg_r;
        wb_jmp  <= op_jmp_r;
      end else if (abort_s) begin
        wb_data <= mem_addr;
        wb_dest <= op_dest_r;
        wb_wreg <= 1'b0;
        wb_jmp  <= op_jmp_r;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: vector table plus scoreboard of expected writebacks.
// Add the timeout abort sequence by defining MEM_TIMEOUT_EN for both bench and RTL.
module tb_mem_access_stage;

  logic        clk, rst;
  logic        in_valid, wmem, rmem, wreg, jmp;
  logic [31:0] alu_res, st_data, mem_rdata;
  logic [3:0]  wr_dest;
  logic        stall, mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic        wb_valid, wb_wreg, wb_jmp, mem_err;
  logic [3:0]  wb_dest;

  typedef struct {
    logic [31:0] alu_res, st_data;
    logic [3:0]  dest;
    logic        wmem, rmem, wreg, jmp;
    int          gnt_dly, rv_dly;
    logic [31:0] rdata, exp_data;
    logic        exp_wreg;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  dest;
    logic        wreg, jmp, err, chk_data;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[10];
  int   checks = 0, failures = 0, issues = 0, memops = 0;
  logic prev_req = 1'b0;

  mem_access_stage #(.DW(32), .RW(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_res(alu_res), .st_data(st_data),
    .wr_dest(wr_dest), .wmem(wmem), .rmem(rmem), .wreg(wreg), .jmp(jmp), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_dest(wb_dest), .wb_wreg(wb_wreg),
    .wb_jmp(wb_jmp), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every writeback pulse is matched against the oldest expectation
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] m;
    if (mem_req && !prev_req) issues++;
    prev_req = mem_req;
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected actual=wb_valid 1 data %h required=no writeback", wb_data);
      end else begin
        e = exp_q.pop_front();
        m = e.chk_data ? 32'hFFFF_FFFF : 32'h0;
        chk("wb_fields", {wb_data & m, wb_dest, wb_wreg, wb_jmp, mem_err},
                         {e.data & m, e.dest, e.wreg, e.jmp, e.err});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic drive_instr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] dst,
                             input logic w, input logic r, input logic wr, input logic j);
    in_valid = 1'b1; alu_res = a; st_data = d; wr_dest = dst;
    wmem = w; rmem = r; wreg = wr; jmp = j;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    @(posedge clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    drive_instr(v.alu_res, v.st_data, v.dest, v.wmem, v.rmem, v.wreg, v.jmp);
    e = '{data: v.exp_data, dest: v.dest, wreg: v.exp_wreg, jmp: v.jmp, err: 1'b0, chk_data: 1'b1};
    exp_q.push_back(e);
    if (v.wmem || v.rmem) memops++;
    @(negedge clk);
    chk("stall_issue", stall, v.wmem || v.rmem);
    if (v.wmem || v.rmem) begin
      for (int d = 0; d < v.gnt_dly; d++) begin
        @(posedge clk); #1;
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;  // must be ignored in REQ
        @(negedge clk);
        chk("req_hold", {mem_req, mem_we, stall}, {1'b1, v.wmem, 1'b1});
        chk("addr_hold", mem_addr, v.alu_res);
        if (v.wmem) chk("wdata_hold", mem_wdata, v.st_data);
      end
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_gnt = 1'b1;
      @(negedge clk);
      chk("gnt_cycle", {mem_req, mem_we, stall}, {1'b1, v.wmem, ~v.wmem});
      chk("gnt_addr", mem_addr, v.alu_res);
      if (!v.wmem) begin
        for (int d = 1; d < v.rv_dly; d++) begin
          @(posedge clk); #1;
          mem_gnt = 1'b0;
          @(negedge clk);
          chk("wait_r", {mem_req, stall}, {1'b0, 1'b1});
        end
        @(posedge clk); #1;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = v.rdata;
        @(negedge clk);
        chk("rvalid_cycle", stall, 1'b0);
      end
    end
  endtask

  initial begin
    exp_t e;
    // fields: alu_res, st_data, dest, wmem, rmem, wreg, jmp, gnt_dly, rv_dly, rdata, exp_data, exp_wreg
    vecs[0] = '{32'h0000_1234, 32'h0, 4'd3,  1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0, 32'h0000_1234, 1'b1};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0, 4'd15, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 32'h0, 32'hFFFF_FFFF, 1'b1};
    vecs[2] = '{32'h0000_0000, 32'h0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 32'h0, 32'h0000_0000, 1'b0};
    vecs[3] = '{32'h0000_0040, 32'hDEAD_BEEF, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0, 32'h0, 32'h0000_0040, 1'b0};
    vecs[4] = '{32'h0000_0080, 32'h0, 4'd5,  1'b0, 1'b1, 1'b1, 1'b0, 0, 2, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1};
    vecs[5] = '{32'h0000_0084, 32'h0, 4'd7,  1'b0, 1'b1, 1'b1, 1'b1, 1, 1, 32'h1234_5678, 32'h1234_5678, 1'b1};
    vecs[6] = '{32'h0000_0090, 32'h55AA_55AA, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0000_0090, 1'b0};
    vecs[7] = '{32'h0000_0100, 32'hA5A5_A5A5, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b1};
    vecs[8] = '{32'h0000_00C0, 32'h1111_2222, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 32'h0, 32'h0000_00C0, 1'b0};
    vecs[9] = '{32'h0000_5678, 32'h0, 4'd6,  1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0, 32'h0000_5678, 1'b1};

    rst = 1'b0; in_valid = 1'b0; wmem = 1'b0; rmem = 1'b0; wreg = 1'b0; jmp = 1'b0;
    alu_res = 32'h0; st_data = 32'h0; wr_dest = 4'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #3;
    chk("reset_outputs", {mem_req, mem_we, wb_valid, wb_wreg, wb_jmp, mem_err, stall}, 7'b0);
    chk("reset_data", {mem_addr, wb_data}, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Table vectors, back to back with in_valid held between instructions
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);
    @(posedge clk); #1;
    in_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a pending request discards the access
    @(posedge clk); #1;
    drive_instr(32'h0000_0200, 32'h0, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0);
    memops++;
    @(posedge clk); #1;
    @(negedge clk);
    chk("req_before_rst", mem_req, 1'b1);
    #2 rst = 1'b0;
    #1 chk("rst_mid_req", {mem_req, wb_valid}, 2'b00);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", {mem_req, stall}, 2'b00);

    // After reset the stage is IDLE: ALU op completes with one cycle latency
    @(posedge clk); #1;
    drive_instr(32'h0000_ABCD, 32'h0, 4'd11, 1'b0, 1'b0, 1'b1, 1'b0);
    e = '{data: 32'h0000_ABCD, dest: 4'd11, wreg: 1'b1, jmp: 1'b0, err: 1'b0, chk_data: 1'b1};
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_latency", wb_valid, 1'b1);

`ifdef MEM_TIMEOUT_EN
    // No grant ever: abort on the 16th waiting cycle
    @(posedge clk); #1;
    drive_instr(32'h0000_0300, 32'h0, 4'd10, 1'b0, 1'b1, 1'b1, 1'b0);
    e = '{data: 32'h0, dest: 4'd10, wreg: 1'b0, jmp: 1'b0, err: 1'b1, chk_data: 1'b0};
    exp_q.push_back(e);
    memops++;
    @(negedge clk);
    chk("tmo_issue_stall", stall, 1'b1);
    for (int i = 1; i < 16; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("tmo_waiting", {mem_req, stall}, 2'b11);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("tmo_abort_cycle", {mem_req, stall}, 2'b10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("tmo_after_abort", {mem_req, mem_err, wb_valid}, 3'b011);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("req_issue_count", issues, memops);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
